// File: rtl/xsimbus_arbiter_pkg.sv
// Shared xSimBus arbiter types: FSM encoding, bus widths and reset values.
// Used by xsimbus_arbiter and xsimbus_rr_picker.
package xsimbus_arbiter_pkg;

  localparam int unsigned XSimBusDeviceBus = 5;
  localparam int unsigned MemAddressBus    = 32;
  localparam int unsigned XSimBusSlots     = 32;
  localparam int unsigned TenureW          = 8;

  // Last-owner reset value chosen so that slot 0 wins the first scan.
  localparam logic [XSimBusDeviceBus-1:0] XSimBusArbResetLastId = 5'd31;

  typedef enum logic [1:0] {
    XSimBusArbIdle = 2'd0,
    XSimBusArbArb  = 2'd1,
    XSimBusArbOwn  = 2'd2
  } xsimbus_arb_state_e;

  function automatic logic [XSimBusSlots-1:0] id_to_onehot(
    input logic [XSimBusDeviceBus-1:0] id
  );
    return {{(XSimBusSlots-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/xsimbus_rr_picker.sv
// Combinational round-robin pick: rotate the request vector so the slot after
// last_id sits at bit 0, priority-encode the lowest set bit, then unrotate.
module xsimbus_rr_picker
  import xsimbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = XSimBusSlots,
  parameter int unsigned ID_W        = XSimBusDeviceBus
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [ID_W-1:0]        last_id_i,
  output logic [ID_W-1:0]        winner_id_o,
  output logic                   any_req_o
);

  logic [ID_W-1:0]        start;
  logic [NUM_MASTERS-1:0] rotated;
  logic [ID_W-1:0]        offset;

  // NUM_MASTERS == 2**ID_W, so the ID arithmetic wraps 31 -> 0 naturally.
  assign start   = last_id_i + ID_W'(1);
  assign rotated = NUM_MASTERS'({req_i, req_i} >> start);

  always_comb begin
    offset = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        offset = ID_W'(i);
      end
    end
  end

  assign winner_id_o = offset + start;
  assign any_req_o   = |req_i;

endmodule

// File: rtl/xsimbus_arbiter.sv
// Round-robin master arbiter for the xSimBus shared bus (IDLE -> ARB -> OWN).
// Optional owner tenure limit with preemption: define XSIMBUS_ARB_TENURE_EN.
module xsimbus_arbiter
  import xsimbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = XSimBusSlots,
  parameter int unsigned ID_W        = XSimBusDeviceBus,
  parameter int unsigned ADDR_W      = MemAddressBus,
  parameter int unsigned MAX_TENURE  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req_in,
  input  logic [NUM_MASTERS-1:0]        lock_in,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr_in,
  output logic [NUM_MASTERS-1:0]        grant_out,
  output logic                          grant_valid_out,
  output logic [ID_W-1:0]               master_id_out,
  output logic [ID_W-1:0]               device_id_out,
  output logic                          hold_flag_out
);

  xsimbus_arb_state_e state_q, state_d;
  logic [ID_W-1:0] master_id_q, master_id_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
  logic [ID_W-1:0] device_id_q, device_id_d;

  logic [ID_W-1:0]        pick_id;
  logic                   pick_any;
  logic [ID_W-1:0]        slot_dev [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] owner_onehot;
  logic                   owner_req;
  logic                   others_req;
  logic                   preempt;
  logic                   unused_addr_bits;

  // Device ID is the top ID_W bits of each slot's address.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slot_dev
    assign slot_dev[g] = addr_in[g*ADDR_W + ADDR_W - 1 -: ID_W];
  end
  assign unused_addr_bits = ^addr_in;

  xsimbus_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_W        (ID_W)
  ) u_picker (
    .req_i       (req_in),
    .last_id_i   (last_id_q),
    .winner_id_o (pick_id),
    .any_req_o   (pick_any)
  );

  assign owner_onehot = id_to_onehot(master_id_q);
  assign owner_req    = req_in[master_id_q];
  assign others_req   = |(req_in & ~owner_onehot);

`ifdef XSIMBUS_ARB_TENURE_EN
  logic [TenureW-1:0] tenure_q, tenure_d;

  always_comb begin
    tenure_d = tenure_q;
    if (state_q == XSimBusArbArb) begin
      tenure_d = '0;
    end else if (state_q == XSimBusArbOwn && tenure_q != '1) begin
      tenure_d = tenure_q + TenureW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tenure_q <= '0;
    end else begin
      tenure_q <= tenure_d;
    end
  end

  // Counter saturates, so a locked owner stays preemptable once its lock drops.
  assign preempt = (state_q == XSimBusArbOwn) &&
                   (tenure_q >= TenureW'(MAX_TENURE - 1)) &&
                   others_req && !lock_in[master_id_q];
`else
  logic unused_lock;
  assign unused_lock = ^{lock_in, TenureW'(MAX_TENURE)};
  assign preempt     = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    master_id_d   = master_id_q;
    last_id_d     = last_id_q;
    device_id_d   = device_id_q;
    hold_flag_out = 1'b0;
    unique case (state_q)
      XSimBusArbIdle: begin
        if (pick_any) begin
          master_id_d = pick_id;
          state_d     = XSimBusArbArb;
        end
      end
      XSimBusArbArb: begin
        hold_flag_out = 1'b1;
        device_id_d   = slot_dev[master_id_q];
        // Winner gave up before the grant: back to IDLE, last_id untouched.
        state_d       = owner_req ? XSimBusArbOwn : XSimBusArbIdle;
      end
      XSimBusArbOwn: begin
        hold_flag_out = others_req;
        device_id_d   = slot_dev[master_id_q];
        if (!owner_req || preempt) begin
          state_d   = XSimBusArbIdle;
          last_id_d = master_id_q;
        end
      end
      default: begin
        state_d = XSimBusArbIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= XSimBusArbIdle;
      master_id_q <= '0;
      last_id_q   <= XSimBusArbResetLastId;
      device_id_q <= '0;
    end else begin
      state_q     <= state_d;
      master_id_q <= master_id_d;
      last_id_q   <= last_id_d;
      device_id_q <= device_id_d;
    end
  end

  assign grant_valid_out = (state_q == XSimBusArbOwn);
  assign grant_out       = grant_valid_out ? owner_onehot : '0;
  assign master_id_out   = master_id_q;
  assign device_id_out   = device_id_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(grant_out));
  a_valid_matches_grant: assert property (@(posedge clk) disable iff (!rst)
    grant_valid_out == (grant_out != '0));

endmodule

// File: tb/tb_xsimbus_arbiter.sv
// Self-checking bench for xsimbus_arbiter: directed scenarios plus random
// traffic, every cycle compared against a slot-level round-robin model.
module tb_xsimbus_arbiter;

`ifdef XSIMBUS_ARB_TENURE_EN
  localparam bit TenureEn = 1'b1;
`else
  localparam bit TenureEn = 1'b0;
`endif
  localparam int unsigned Tenure = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   req_in;
  logic [31:0]   lock_in;
  logic [1023:0] addr_in;
  logic [31:0]   grant_out;
  logic          grant_valid_out;
  logic [4:0]    master_id_out;
  logic [4:0]    device_id_out;
  logic          hold_flag_out;

  logic [31:0] addr_arr [32];

  always #5 clk = ~clk;

  xsimbus_arbiter #(
    .NUM_MASTERS (32),
    .ID_W        (5),
    .ADDR_W      (32),
    .MAX_TENURE  (Tenure)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_in          (req_in),
    .lock_in         (lock_in),
    .addr_in         (addr_in),
    .grant_out       (grant_out),
    .grant_valid_out (grant_valid_out),
    .master_id_out   (master_id_out),
    .device_id_out   (device_id_out),
    .hold_flag_out   (hold_flag_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, who is being arbitrated, who went last.
  int         m_owner;
  int         m_cand;
  int         m_last;
  int         m_held;
  logic [4:0] m_mid;
  logic [4:0] m_dev;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [31:0] req, input int last);
    for (int k = 1; k <= 32; k++) begin
      int s;
      s = (last + k) % 32;
      if (req[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cand  = -1;
    m_last  = 31;
    m_held  = 0;
    m_mid   = 5'd0;
    m_dev   = 5'd0;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_grant;
    logic        exp_hold;
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    if (m_cand >= 0) exp_hold = 1'b1;
    else if (m_owner >= 0) exp_hold = ((req_in & ~exp_grant) != 32'd0);
    else exp_hold = 1'b0;
    check_val("grant", grant_out, exp_grant);
    check_val("grant_valid", {31'd0, grant_valid_out}, {31'd0, m_owner >= 0});
    check_val("master_id", {27'd0, master_id_out}, {27'd0, m_mid});
    check_val("device_id", {27'd0, device_id_out}, {27'd0, m_dev});
    check_val("hold_flag", {31'd0, hold_flag_out}, {31'd0, exp_hold});
  endtask

  task automatic model_step();
    if (m_cand >= 0) begin
      m_dev = addr_arr[m_cand][31:27];
      if (req_in[m_cand]) begin
        m_owner = m_cand;
        m_held  = 0;
      end
      m_cand = -1;
    end else if (m_owner >= 0) begin
      m_dev = addr_arr[m_owner][31:27];
      m_held++;
      if (!req_in[m_owner] ||
          (TenureEn && m_held >= int'(Tenure) &&
           (req_in & ~(32'd1 << m_owner)) != 32'd0 && !lock_in[m_owner])) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (req_in != 32'd0) begin
      m_cand = rr_pick(req_in, m_last);
      m_mid  = 5'(m_cand);
    end
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input logic [31:0] req, input logic [31:0] lock);
    req_in  = req;
    lock_in = lock;
    for (int i = 0; i < 32; i++) addr_in[i*32 +: 32] = addr_arr[i];
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] l;
    int          idx;

    rst     = 1'b0;
    req_in  = '0;
    lock_in = '0;
    addr_in = '0;
    for (int i = 0; i < 32; i++) addr_arr[i] = 32'd0;
    model_reset();
    @(negedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single requester: grant in the third cycle after the request.
    addr_arr[0] = 32'h0000_0100;
    step(32'h1, 32'h0);
    step(32'h1, 32'h0);
    check_val("t1_grant_c2", grant_out, 32'h1);
    check_val("t1_master", {27'd0, master_id_out}, 32'd0);
    step(32'h1, 32'h0);
    step(32'h0, 32'h0);
    repeat (3) step(32'h0, 32'h0);

    // Slots 29 and 31 from reset: 29 first, 31 three cycles after release.
    pulse_reset();
    addr_arr[29] = 32'hE800_0000;
    addr_arr[31] = 32'hF800_0000;
    step(32'hA000_0000, 32'h0);
    step(32'hA000_0000, 32'h0);
    check_val("t2_master29", {27'd0, master_id_out}, 32'd29);
    check_val("t2_dev29", {27'd0, device_id_out}, 32'd29);
    check_val("t2_hold", {31'd0, hold_flag_out}, 32'd1);
    repeat (3) step(32'hA000_0000, 32'h0);
    step(32'h8000_0000, 32'h0);
    check_val("t2_drop", grant_out, 32'h0);
    repeat (2) step(32'h8000_0000, 32'h0);
    check_val("t2_grant31", grant_out, 32'h8000_0000);
    check_val("t2_dev31", {27'd0, device_id_out}, 32'd31);
    step(32'h8000_0000, 32'h0);
    repeat (2) step(32'h0, 32'h0);

    // Wrap-around: last owner 30, requests on 2 and 30 -> slot 2.
    pulse_reset();
    repeat (3) step(32'h4000_0000, 32'h0);
    step(32'h0, 32'h0);
    repeat (2) step(32'h4000_0004, 32'h0);
    check_val("t3_wrap_master", {27'd0, master_id_out}, 32'd2);
    check_val("t3_wrap_grant", grant_out, 32'h4);
    step(32'h0, 32'h0);
    repeat (2) step(32'h0, 32'h0);

    // Winner drops during ARB: no grant, last_id stays 31, so 5 beats 7.
    pulse_reset();
    step(32'h20, 32'h0);
    step(32'h0, 32'h0);
    check_val("t4_no_grant", grant_out, 32'h0);
    step(32'h0, 32'h0);
    repeat (2) step(32'hA0, 32'h0);
    check_val("t4_master5", {27'd0, master_id_out}, 32'd5);
    check_val("t4_grant5", grant_out, 32'h20);
    step(32'h0, 32'h0);
    repeat (2) step(32'h0, 32'h0);

`ifdef XSIMBUS_ARB_TENURE_EN
    // Always-requesting slot 31 is preempted after MAX_TENURE cycles.
    pulse_reset();
    repeat (2) step(32'h8000_0000, 32'h0);
    repeat (4) step(32'hA000_0000, 32'h0);
    check_val("t5_preempt", grant_out, 32'h0);
    repeat (2) step(32'hA000_0000, 32'h0);
    check_val("t5_grant29", grant_out, 32'h2000_0000);
    step(32'h8000_0000, 32'h0);
    repeat (3) step(32'h8000_0000, 32'h0);
    // Same again with slot 31 locked: no preemption.
    pulse_reset();
    repeat (2) step(32'h8000_0000, 32'h8000_0000);
    repeat (8) step(32'hA000_0000, 32'h8000_0000);
    check_val("t5_locked", grant_out, 32'h8000_0000);
    step(32'h0, 32'h0);
    repeat (2) step(32'h0, 32'h0);
`endif

    // Reset mid-OWN clears outputs at once; afterwards slot 0 has priority.
    pulse_reset();
    repeat (3) step(32'h1, 32'h0);
    step(32'h0, 32'h0);
    repeat (3) step(32'h2, 32'h0);
    check_val("t6_owner1", grant_out, 32'h2);
    pulse_reset();
    repeat (2) step(32'h3, 32'h0);
    check_val("t6_master0", {27'd0, master_id_out}, 32'd0);
    check_val("t6_grant0", grant_out, 32'h1);
    step(32'h0, 32'h0);
    repeat (2) step(32'h0, 32'h0);

    // Random traffic: sticky requests, occasional lock flips and address edits.
    r = 32'h0;
    l = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 32; b++) begin
        if (r[b]) begin
          if ($urandom_range(11) == 0) r[b] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          r[b] = 1'b1;
        end
      end
      if ($urandom_range(63) == 0) begin
        idx    = int'($urandom_range(31));
        l[idx] = ~l[idx];
      end
      if ($urandom_range(3) == 0) begin
        idx           = int'($urandom_range(31));
        addr_arr[idx] = $urandom();
      end
      step(r, l);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
